// File: rtl/sr_pkg.sv
// Shared types and defaults for the s/r command conditioner.
package sr_pkg;

   // Per-channel debounce FSM states.
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } deb_state_e;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/sr_cmd_conditioner_if.sv
// Command bus: raw set/reset requests in, conditioned s/r pulses and conflict flag out.
interface sr_cmd_conditioner_if;

   logic set_in;
   logic reset_in;
   logic s;
   logic r;
   logic conflict;

   modport master (output set_in, output reset_in, input s, input r, input conflict);
   modport slave  (input set_in, input reset_in, output s, output r, output conflict);

endinterface

// File: rtl/sr_debounce_chan.sv
// One raw input channel: synchroniser, debounce FSM and rising-edge strobe.
module sr_debounce_chan
   import sr_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic rise_strobe
);

   localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   deb_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rise_q, rise_d;
   logic                   sync;

   assign sync        = sync_q[SYNC_STAGES-1];
   assign rise_strobe = rise_q;

   // Shift the raw level through the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw};
   end

   // Debounce next-state: a level change must persist DEBOUNCE_CYCLES cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (sync) begin
               state_d = CHK_HI;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_HI: begin
            if (!sync) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!sync) begin
               state_d = CHK_LO;
               cnt_d   = CNT_W'(1);
            end
         end
         CHK_LO: begin
            if (sync) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Channel registers; reset clears everything including a strobe in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
      end
   end

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns bouncy set/reset requests into clean, mutually exclusive s/r pulses.
module sr_cmd_conditioner
   import sr_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   sr_cmd_conditioner_if.slave  cmd
);

   logic set_rise;
   logic reset_rise;
   logic s_q, s_d;
   logic r_q, r_d;
   logic conflict_q, conflict_d;

   sr_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_set_chan (
      .clk         (clk),
      .rst         (rst),
      .raw         (cmd.set_in),
      .rise_strobe (set_rise)
   );

   sr_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_reset_chan (
      .clk         (clk),
      .rst         (rst),
      .raw         (cmd.reset_in),
      .rise_strobe (reset_rise)
   );

   // Arbitration: reset wins a same-cycle tie and the set is dropped.
   always_comb begin
      s_d        = set_rise & ~reset_rise;
      r_d        = reset_rise;
      conflict_d = set_rise & reset_rise;
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
      end
   end

   assign cmd.s        = s_q;
   assign cmd.r        = r_q;
   assign cmd.conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner with a behavioural downstream s/r flop.
module tb_sr_cmd_conditioner;
   import sr_pkg::*;

   localparam int unsigned DEB  = 4;
   localparam int unsigned SYNC = 2;
   localparam int          LAT  = DEB + SYNC;   // pulse visible after edge E0+LAT

   logic clk;
   logic rst;
   logic ff_out;
   int   tests_run;
   int   tests_failed;

   sr_cmd_conditioner_if bus ();

   sr_cmd_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYNC)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .cmd (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream srFlipFlop model fed by the conditioned pulses.
   always @(posedge clk) begin
      if (rst) ff_out <= 1'b0;
      else begin
         case ({bus.s, bus.r})
            2'b10:   ff_out <= 1'b1;
            2'b01:   ff_out <= 1'b0;
            2'b11:   ff_out <= 1'bx;
            default: ff_out <= ff_out;
         endcase
      end
   end

   // Advance one edge, sample 1 time unit later, and check the s&r invariant.
   task automatic tick();
      @(posedge clk);
      #1;
      tests_run++;
      if ((bus.s & bus.r) !== 1'b0 || $isunknown(ff_out)) begin
         tests_failed++;
         $display("FAIL invariant t=%0t s=%b r=%b ff_out=%b required s&r=0 and ff_out known",
                  $time, bus.s, bus.r, ff_out);
      end
   endtask

   task automatic settle();
      bus.set_in   = 1'b0;
      bus.reset_in = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.set_in   = 1'b0;
      bus.reset_in = 1'b0;
      tick();
      tick();
      tests_run++;
      if (bus.s !== 1'b0 || bus.r !== 1'b0 || bus.conflict !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs got s=%b r=%b c=%b required 0 0 0", bus.s, bus.r, bus.conflict);
      end
      tests_run++;
      if (u_dut.u_set_chan.state_q !== STABLE_LO || u_dut.u_reset_chan.state_q !== STABLE_LO) begin
         tests_failed++;
         $display("FAIL reset_state got %0d/%0d required STABLE_LO",
                  u_dut.u_set_chan.state_q, u_dut.u_reset_chan.state_q);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_clean_set();
      bus.set_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         tests_run++;
         if (bus.s !== (k == LAT) || bus.r !== 1'b0 || bus.conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_set k=%0d got s=%b r=%b c=%b required s=%b r=0 c=0",
                     k, bus.s, bus.r, bus.conflict, (k == LAT));
         end
      end
      settle();
   endtask

   task automatic test_bounce();
      logic pat [8];
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         bus.reset_in = pat[i];
         tick();
         tests_run++;
         if (bus.r !== 1'b0 || bus.s !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_quiet i=%0d got r=%b s=%b required 0 0", i, bus.r, bus.s);
         end
      end
      bus.reset_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         tests_run++;
         if (bus.r !== (k == LAT) || bus.s !== 1'b0 || bus.conflict !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_pulse k=%0d got r=%b s=%b c=%b required r=%b s=0 c=0",
                     k, bus.r, bus.s, bus.conflict, (k == LAT));
         end
      end
      settle();
   endtask

   task automatic test_glitch();
      bus.set_in = 1'b1;
      repeat (3) tick();
      bus.set_in = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         tests_run++;
         if (bus.s !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_no_pulse k=%0d got s=%b required 0", k, bus.s);
         end
      end
      tests_run++;
      if (u_dut.u_set_chan.state_q !== STABLE_LO || u_dut.u_set_chan.cnt_q !== '0) begin
         tests_failed++;
         $display("FAIL glitch_state got state=%0d cnt=%0d required STABLE_LO cnt=0",
                  u_dut.u_set_chan.state_q, u_dut.u_set_chan.cnt_q);
      end
      settle();
   endtask

   task automatic test_simultaneous();
      bus.set_in   = 1'b1;
      bus.reset_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         tests_run++;
         if (bus.r !== (k == LAT) || bus.conflict !== (k == LAT) || bus.s !== 1'b0) begin
            tests_failed++;
            $display("FAIL simultaneous k=%0d got s=%b r=%b c=%b required s=0 r=%b c=%b",
                     k, bus.s, bus.r, bus.conflict, (k == LAT), (k == LAT));
         end
      end
      settle();
   endtask

   task automatic test_reset_mid();
      bus.set_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests_run++;
         if (bus.s !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_pre k=%0d got s=%b required 0", k, bus.s);
         end
      end
      rst = 1'b1;
      tick();
      tests_run++;
      if (bus.s !== 1'b0 || u_dut.u_set_chan.state_q !== STABLE_LO || u_dut.u_set_chan.cnt_q !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_clear got s=%b state=%0d cnt=%0d required 0 STABLE_LO 0",
                  bus.s, u_dut.u_set_chan.state_q, u_dut.u_set_chan.cnt_q);
      end
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         tests_run++;
         if (bus.s !== (k == LAT) || bus.r !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_post k=%0d got s=%b r=%b required s=%b r=0",
                     k, bus.s, bus.r, (k == LAT));
         end
      end
      settle();
   endtask

   task automatic test_integration();
      bus.set_in = 1'b1;
      repeat (LAT + 3) tick();
      tests_run++;
      if (ff_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL integ_set got out=%b required 1", ff_out);
      end
      settle();
      bus.reset_in = 1'b1;
      repeat (LAT + 3) tick();
      tests_run++;
      if (ff_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL integ_reset got out=%b required 0", ff_out);
      end
      settle();
      bus.set_in   = 1'b1;
      bus.reset_in = 1'b1;
      repeat (LAT + 3) tick();
      tests_run++;
      if (ff_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL integ_both got out=%b required 0", ff_out);
      end
      settle();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      bus.set_in   = 1'b0;
      bus.reset_in = 1'b0;
      test_reset();
      test_clean_set();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_integration();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
